// File: rtl/fifo_rd_if.sv
// Read-side handshake bundle for the asynchronous FIFO read controller.
//   rinc      : read request from the consumer
//   wptr_gray : write-domain Gray pointer (asynchronous to rclk)
//   raddr     : memory read address
//   rptr      : registered Gray read pointer, crosses to the write domain
//   rempty    : registered empty flag
//   rlevel    : registered read-side occupancy, 0..2^ADDR_SIZE
//   rq2_wptr  : synchronized write pointer (visibility only)
//   rundf     : sticky underflow flag, present only with RD_UNDERFLOW_FLAG_EN
// Modports: master = consumer/write-pointer source, slave = fifo_rd_ctrl.
interface fifo_rd_if #(
    parameter int unsigned ADDR_SIZE = 3
);
    logic                 rinc;
    logic [ADDR_SIZE:0]   wptr_gray;
    logic [ADDR_SIZE-1:0] raddr;
    logic [ADDR_SIZE:0]   rptr;
    logic                 rempty;
    logic [ADDR_SIZE:0]   rlevel;
    logic [ADDR_SIZE:0]   rq2_wptr;
`ifdef RD_UNDERFLOW_FLAG_EN
    logic                 rundf;
`endif

    modport master (
        output rinc, wptr_gray,
`ifdef RD_UNDERFLOW_FLAG_EN
        input  rundf,
`endif
        input  raddr, rptr, rempty, rlevel, rq2_wptr
    );

    modport slave (
        input  rinc, wptr_gray,
`ifdef RD_UNDERFLOW_FLAG_EN
        output rundf,
`endif
        output raddr, rptr, rempty, rlevel, rq2_wptr
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for the asynchronous FIFO.
// Keeps the binary read pointer and its Gray copy, synchronizes the write-domain
// Gray pointer with two flops, and derives the empty flag and read-side occupancy.
// Ports:
//   rclk : read-domain clock
//   rrst : asynchronous active-high reset
//   bus  : fifo_rd_if.slave (rinc, wptr_gray in; raddr, rptr, rempty, rlevel,
//          rq2_wptr out; rundf out when RD_UNDERFLOW_FLAG_EN is defined)
// Optional feature macro: RD_UNDERFLOW_FLAG_EN adds a sticky read-on-empty flag.
module fifo_rd_ctrl #(
    parameter int unsigned ADDR_SIZE = 3
) (
    input logic       rclk,
    input logic       rrst,
    fifo_rd_if.slave  bus
);
    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] rptr_q;
    logic [ADDR_SIZE:0] wq1;
    logic [ADDR_SIZE:0] rq2_wptr_q;
    logic [ADDR_SIZE:0] rlevel_q;
    logic               rempty_q;

    logic               pop;
    logic [ADDR_SIZE:0] rbin_next;
    logic [ADDR_SIZE:0] rgray_next;
    logic [ADDR_SIZE:0] wbin_s;

    always_comb begin
        pop        = bus.rinc & ~rempty_q;
        rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, pop};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        // Gray to binary: each bit is the XOR of all Gray bits at and above it.
        wbin_s = '0;
        for (int i = 0; i <= int'(ADDR_SIZE); i++) begin
            wbin_s[i] = ^(rq2_wptr_q >> i);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin       <= '0;
            rptr_q     <= '0;
            wq1        <= '0;
            rq2_wptr_q <= '0;
            rempty_q   <= 1'b1;
            rlevel_q   <= '0;
        end else begin
            rbin       <= rbin_next;
            rptr_q     <= rgray_next;
            wq1        <= bus.wptr_gray;
            rq2_wptr_q <= wq1;
            // Both flags use the post-pop pointer so a last-word pop empties on this edge,
            // and share operands so rempty and rlevel==0 always agree.
            rempty_q   <= (rgray_next == rq2_wptr_q);
            rlevel_q   <= wbin_s - rbin_next;
        end
    end

`ifdef RD_UNDERFLOW_FLAG_EN
    logic rundf_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rundf_q <= 1'b0;
        end else begin
            rundf_q <= rundf_q | (bus.rinc & rempty_q);
        end
    end

    assign bus.rundf = rundf_q;
`endif

    assign bus.raddr    = rbin[ADDR_SIZE-1:0];
    assign bus.rptr     = rptr_q;
    assign bus.rempty   = rempty_q;
    assign bus.rlevel   = rlevel_q;
    assign bus.rq2_wptr = rq2_wptr_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_SIZE = 3).
module tb_fifo_rd_ctrl;
    logic rclk = 1'b0;
    logic rrst = 1'b1;

    fifo_rd_if #(.ADDR_SIZE(3)) bus ();

    fifo_rd_ctrl #(.ADDR_SIZE(3)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    int tests = 0;
    int fails = 0;

    // Reference model: counts of words written and read, plus the write count as
    // the read side sees it one and two edges later.
    logic [3:0] w_cnt;
    logic [3:0] m_r;
    logic [3:0] m_h1;
    logic [3:0] m_h2;
    logic [3:0] m_level;
    logic       m_empty;
    logic       m_undf;

    typedef struct {
        logic       rst;
        logic       inc;
        logic [3:0] wcnt;
        logic [2:0] raddr;
        logic [3:0] rptr;
        logic       empty;
        logic [3:0] level;
        logic [3:0] rq2;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_w(input logic [3:0] n);
        w_cnt         = n;
        bus.wptr_gray = gray(n);
    endtask

    task automatic model_reset();
        m_r     = '0;
        m_h1    = '0;
        m_h2    = '0;
        m_level = '0;
        m_empty = 1'b1;
        m_undf  = 1'b0;
    endtask

    // Advance one rclk edge, update the model from the inputs seen at that edge.
    task automatic step();
        logic       inc_at;
        logic       rst_at;
        logic [3:0] w_at;
        inc_at = bus.rinc;
        rst_at = rrst;
        w_at   = w_cnt;
        @(posedge rclk);
        #1;
        if (rst_at) begin
            model_reset();
        end else begin
            if (inc_at && m_empty) m_undf = 1'b1;
            if (inc_at && !m_empty) m_r = m_r + 4'd1;
            m_level = m_h2 - m_r;
            m_empty = (m_level == 4'd0);
            m_h2    = m_h1;
            m_h1    = w_at;
        end
    endtask

    task automatic compare_model();
        chk("m_raddr", int'(bus.raddr), int'(m_r[2:0]));
        chk("m_rptr", int'(bus.rptr), int'(gray(m_r)));
        chk("m_rempty", int'(bus.rempty), int'(m_empty));
        chk("m_rlevel", int'(bus.rlevel), int'(m_level));
        chk("m_rq2_wptr", int'(bus.rq2_wptr), int'(gray(m_h2)));
`ifdef RD_UNDERFLOW_FLAG_EN
        chk("m_rundf", int'(bus.rundf), int'(m_undf));
`endif
    endtask

    task automatic do_reset();
        rrst     = 1'b1;
        bus.rinc = 1'b0;
        set_w(4'd0);
        step();
        rrst = 1'b0;
        compare_model();
    endtask

    logic [3:0] diff;
    logic [3:0] prev_rptr;
    logic [2:0] prev_raddr;
    logic       saw_gray_wrap;
    logic       saw_addr_wrap;
    int         nw;

    initial begin
        bus.rinc = 1'b0;
        set_w(4'd0);
        model_reset();

        //                rst   inc   wcnt   raddr rptr     empty level  rq2
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 3'd0, 4'b0000, 1'b1, 4'd0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 4'd1, 3'd0, 4'b0000, 1'b1, 4'd0, 4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 4'd1, 3'd0, 4'b0000, 1'b1, 4'd0, 4'b0001};
        vecs[3]  = '{1'b0, 1'b0, 4'd1, 3'd0, 4'b0000, 1'b0, 4'd1, 4'b0001};
        vecs[4]  = '{1'b0, 1'b1, 4'd1, 3'd1, 4'b0001, 1'b1, 4'd0, 4'b0001};
        vecs[5]  = '{1'b0, 1'b1, 4'd1, 3'd1, 4'b0001, 1'b1, 4'd0, 4'b0001};
        vecs[6]  = '{1'b1, 1'b0, 4'd1, 3'd0, 4'b0000, 1'b1, 4'd0, 4'b0000};
        vecs[7]  = '{1'b0, 1'b0, 4'd8, 3'd0, 4'b0000, 1'b1, 4'd0, 4'b0000};
        vecs[8]  = '{1'b0, 1'b0, 4'd8, 3'd0, 4'b0000, 1'b1, 4'd0, 4'b1100};
        vecs[9]  = '{1'b0, 1'b0, 4'd8, 3'd0, 4'b0000, 1'b0, 4'd8, 4'b1100};
        vecs[10] = '{1'b0, 1'b1, 4'd8, 3'd1, 4'b0001, 1'b0, 4'd7, 4'b1100};
        vecs[11] = '{1'b0, 1'b0, 4'd8, 3'd1, 4'b0001, 1'b0, 4'd7, 4'b1100};

        // Directed vectors: reset, single write, last-word pop, read on empty, full level.
        for (int i = 0; i < 12; i++) begin
            rrst     = vecs[i].rst;
            bus.rinc = vecs[i].inc;
            set_w(vecs[i].wcnt);
            step();
            chk("v_raddr", int'(bus.raddr), int'(vecs[i].raddr));
            chk("v_rptr", int'(bus.rptr), int'(vecs[i].rptr));
            chk("v_rempty", int'(bus.rempty), int'(vecs[i].empty));
            chk("v_rlevel", int'(bus.rlevel), int'(vecs[i].level));
            chk("v_rq2_wptr", int'(bus.rq2_wptr), int'(vecs[i].rq2));
            compare_model();
        end
        rrst = 1'b0;

        // Asynchronous reset mid-stream with a non-zero write pointer.
        bus.rinc = 1'b0;
        set_w(4'd6);
        for (int i = 0; i < 4; i++) begin
            step();
            compare_model();
        end
        #2;
        rrst = 1'b1;
        #1;
        chk("async_rempty", int'(bus.rempty), 1);
        chk("async_rptr", int'(bus.rptr), 0);
        chk("async_raddr", int'(bus.raddr), 0);
        chk("async_rlevel", int'(bus.rlevel), 0);
        chk("async_rq2", int'(bus.rq2_wptr), 0);
        step();
        compare_model();
        do_reset();

        // Concurrent pop and synchronized write-pointer advance.
        set_w(4'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            compare_model();
        end
        chk("conc_level_pre", int'(bus.rlevel), 3);
        set_w(4'd4);
        step();
        compare_model();
        step();
        compare_model();
        bus.rinc = 1'b1;
        step();
        bus.rinc = 1'b0;
        compare_model();
        chk("conc_level", int'(bus.rlevel), 3);
        chk("conc_rempty", int'(bus.rempty), 0);
        chk("conc_raddr", int'(bus.raddr), 1);

        // Wrap: 20 writes, pops lagging behind.
        do_reset();
        saw_gray_wrap = 1'b0;
        saw_addr_wrap = 1'b0;
        nw = 0;
        for (int c = 0; c < 45; c++) begin
            if (nw < 20) begin
                set_w(w_cnt + 4'd1);
                nw++;
            end
            bus.rinc   = (c >= 3);
            prev_rptr  = bus.rptr;
            prev_raddr = bus.raddr;
            step();
            compare_model();
            if (prev_rptr == 4'b1000 && bus.rptr == 4'b0000) saw_gray_wrap = 1'b1;
            if (prev_raddr == 3'd7 && bus.raddr == 3'd0) saw_addr_wrap = 1'b1;
        end
        bus.rinc = 1'b0;
        chk("wrap_gray_seen", int'(saw_gray_wrap), 1);
        chk("wrap_addr_seen", int'(saw_addr_wrap), 1);
        chk("wrap_final_rempty", int'(bus.rempty), 1);
        chk("wrap_final_rlevel", int'(bus.rlevel), 0);
        chk("wrap_final_raddr", int'(bus.raddr), 4);

        // Randomized traffic against the model, never overfilling the FIFO.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            diff = w_cnt - m_r;
            if ($urandom_range(0, 2) != 0 && diff < 4'd8) set_w(w_cnt + 4'd1);
            bus.rinc = 1'($urandom_range(0, 1));
            step();
            compare_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
